regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 96 +++++++++
 tb/tb_regfile_scoreboard.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard for in-order issue.
// Two combinational read ports with optional writeback forwarding.
module regfile_scoreboard #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int AW        = 5,
  parameter int BYPASS    = 1,
  parameter int RST_INDEX = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW:0]     busy_cnt
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic             wb_act;
  logic             iss_act;

  assign wb_act = wb_valid && !rst && (wb_addr != '0);

  assign issue_ready = rst || (issue_rd == '0) ||
                       !busy[issue_rd] ||
                       (wb_valid && (wb_addr == issue_rd));

  assign iss_act = issue_valid && issue_ready &&
                   !rst && (issue_rd != '0);

  // Set is applied after clear so a same-edge re-issue keeps the bit.
  always_comb begin
    busy_nxt = busy;
    if (wb_act)
      busy_nxt[wb_addr] = 1'b0;
    if (iss_act)
      busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (RST_INDEX != 0) ? XLEN'(i) : '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wb_act)
        regs[wb_addr] <= wb_data;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    rd1      = regs[rs1_addr];
    rs1_busy = busy[rs1_addr];
    if (rs1_addr == '0) begin
      rd1      = '0;
      rs1_busy = 1'b0;
    end else if ((BYPASS != 0) && wb_act &&
                 (wb_addr == rs1_addr)) begin
      rd1      = wb_data;
      rs1_busy = 1'b0;
    end
  end

  always_comb begin
    rd2      = regs[rs2_addr];
    rs2_busy = busy[rs2_addr];
    if (rs2_addr == '0) begin
      rd2      = '0;
      rs2_busy = 1'b0;
    end else if ((BYPASS != 0) && wb_act &&
                 (wb_addr == rs2_addr)) begin
      rd2      = wb_data;
      rs2_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench: forwarding and non-forwarding instances run against
// an array-based reference model under directed and random traffic.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;

  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_b1, a_b2, b_b1, b_b2;
  logic        a_rdy, b_rdy;
  logic [5:0]  a_cnt, b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  bit          mb    [32];

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .XLEN(32), .NREGS(32), .AW(5),
    .BYPASS(1), .RST_INDEX(1)
  ) u_byp (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1(a_rd1), .rd2(a_rd2),
    .rs1_busy(a_b1), .rs2_busy(a_b2),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(a_rdy),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .busy_cnt(a_cnt)
  );

  regfile_scoreboard #(
    .XLEN(32), .NREGS(32), .AW(5),
    .BYPASS(0), .RST_INDEX(0)
  ) u_nob (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1(b_rd1), .rd2(b_rd2),
    .rs1_busy(b_b1), .rs2_busy(b_b2),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(b_rdy),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .busy_cnt(b_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit fwd(input int byp, input logic [4:0] a);
    return byp != 0 && !rst && wb_valid && wb_addr != 0 && wb_addr == a;
  endfunction

  function automatic logic [31:0] exp_rd(input int byp,
                                         input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (fwd(byp, a)) return wb_data;
    return byp != 0 ? mem_a[a] : mem_b[a];
  endfunction

  function automatic bit exp_busy(input int byp, input logic [4:0] a);
    if (a == 0 || fwd(byp, a)) return 1'b0;
    return mb[a];
  endfunction

  function automatic bit exp_rdy();
    return rst || issue_rd == 0 || !mb[issue_rd] ||
           (wb_valid && wb_addr == issue_rd);
  endfunction

  function automatic int exp_cnt();
    int s = 0;
    foreach (mb[i]) s += mb[i];
    return s;
  endfunction

  task automatic model_reset();
    foreach (mb[i]) begin
      mb[i]    = 1'b0;
      mem_a[i] = 32'(i);
      mem_b[i] = 32'h0;
    end
  endtask

  task automatic check_all();
    chk("byp_rd1", a_rd1, exp_rd(1, rs1_addr));
    chk("byp_rd2", a_rd2, exp_rd(1, rs2_addr));
    chk("byp_b1",  a_b1,  exp_busy(1, rs1_addr));
    chk("byp_b2",  a_b2,  exp_busy(1, rs2_addr));
    chk("byp_rdy", a_rdy, exp_rdy());
    chk("byp_cnt", a_cnt, exp_cnt());
    chk("nob_rd1", b_rd1, exp_rd(0, rs1_addr));
    chk("nob_rd2", b_rd2, exp_rd(0, rs2_addr));
    chk("nob_b1",  b_b1,  exp_busy(0, rs1_addr));
    chk("nob_b2",  b_b2,  exp_busy(0, rs2_addr));
    chk("nob_rdy", b_rdy, exp_rdy());
    chk("nob_cnt", b_cnt, exp_cnt());
  endtask

  // Inputs are set at the falling edge; check, then advance the model.
  task automatic cyc();
    bit rdy;
    #1;
    check_all();
    rdy = exp_rdy();
    @(posedge clk);
    if (!rst) begin
      if (wb_valid && wb_addr != 0) begin
        mem_a[wb_addr] = wb_data;
        mem_b[wb_addr] = wb_data;
        mb[wb_addr]    = 1'b0;
      end
      if (issue_valid && rdy && issue_rd != 0)
        mb[issue_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    wb_valid    = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rs1_addr = 5'd7;
    rs2_addr = 5'd0;
    #1;
    check_all();
    rst = 1'b0;
    cyc();
    chk("reset_rd1_7", a_rd1, 32'd7);

    // Re-issue of a busy destination stalls until its writeback.
    issue_valid = 1'b1; issue_rd = 5'd5;
    cyc();
    cyc();
    chk("stall_rdy", a_rdy, 1'b0);
    chk("stall_cnt", a_cnt, 6'd1);
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    cyc();
    idle();
    rs1_addr = 5'd5;
    cyc();
    chk("reissue_rd", a_rd1, 32'hDEADBEEF);
    chk("reissue_busy", a_b1, 1'b1);

    // Same-cycle forwarding on both ports.
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h12345678;
    rs1_addr = 5'd9; rs2_addr = 5'd9;
    cyc();
    idle();
    cyc();
    chk("nob_after_edge", b_rd1, 32'h12345678);

    // Register zero ignores writes and issues.
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
    cyc();
    idle();
    cyc();
    chk("r0_cnt", a_cnt, 6'd1);

    // Retire r5, then reserve every register.
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    cyc();
    idle();
    for (int r = 1; r < 32; r++) begin
      issue_valid = 1'b1; issue_rd = 5'(r);
      cyc();
    end
    idle();
    rs1_addr = 5'd7; rs2_addr = 5'd31;
    cyc();
    chk("full_cnt", a_cnt, 6'd31);

    // Asynchronous reset between edges.
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_cnt", a_cnt, 6'd0);
    chk("async_b1", a_b1, 1'b0);
    chk("async_rd2", a_rd2, 32'd31);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 400; n++) begin
      rs1_addr    = 5'($urandom_range(0, 31));
      rs2_addr    = ($urandom_range(0, 3) == 0) ? rs1_addr
                                                : 5'($urandom_range(0, 31));
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      wb_valid    = 1'($urandom_range(0, 1));
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      if ($urandom_range(0, 3) == 0)
        wb_addr = issue_rd;
      cyc();
    end
    idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
